// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit in the EX stage.
// Multiplication uses shift-add and division uses restoring steps, both one bit
// per cycle over a shared 64-bit accumulator.
// Optional build macro EX_MULDIV_FAST_MUL_EN: MUL* operations use a
// single-cycle multiplier and finish one cycle after the start is accepted.
module ex_muldiv (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic        s_start_i,
   input  logic [2:0]  s_funct_i,
   input  logic [31:0] s_op1_i,
   input  logic [31:0] s_op2_i,
   input  logic        s_flush_i,
   input  logic        s_hold_i,
   output logic        s_stall_o,
   output logic        s_busy_o,
   output logic        s_done_o,
   output logic [31:0] s_result_o
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned AccW = 2 * XLEN;
   localparam int unsigned CntW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2:0]          funct_q, funct_d;
   logic [AccW-1:0]     acc_q, acc_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic                res_neg_q, res_neg_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                done_q, busy_q;
   logic                stall_c;

   logic                op1_signed_c, op2_signed_c, op1_neg_c, op2_neg_c;
   logic [XLEN-1:0]     op1_mag_c, op2_mag_c;
   logic [XLEN:0]       add_c, sub_c;
   logic [AccW-1:0]     step_c, prod_c;
   logic [XLEN-1:0]     fin_c;

   // Operand signedness and magnitudes from the incoming funct3
   always_comb begin
      op1_signed_c = (s_funct_i == 3'd0) || (s_funct_i == 3'd1) || (s_funct_i == 3'd2) ||
                     (s_funct_i == 3'd4) || (s_funct_i == 3'd6);
      op2_signed_c = (s_funct_i == 3'd0) || (s_funct_i == 3'd1) ||
                     (s_funct_i == 3'd4) || (s_funct_i == 3'd6);
      op1_neg_c    = op1_signed_c && s_op1_i[XLEN-1];
      op2_neg_c    = op2_signed_c && s_op2_i[XLEN-1];
      op1_mag_c    = op1_neg_c ? XLEN'(-s_op1_i) : s_op1_i;
      op2_mag_c    = op2_neg_c ? XLEN'(-s_op2_i) : s_op2_i;
   end

   // One shift-add (multiply) or restoring (divide) step, plus sign-corrected result
   always_comb begin
      add_c = {1'b0, acc_q[AccW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      sub_c = {acc_q[AccW-1:XLEN], acc_q[XLEN-1]} - {1'b0, mcand_q};
      if (!funct_q[2]) begin
         step_c = {add_c, acc_q[XLEN-1:1]};
      end else if (!sub_c[XLEN]) begin
         step_c = {sub_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         step_c = {acc_q[AccW-2:0], 1'b0};
      end
      prod_c = res_neg_q ? AccW'(-step_c) : step_c;
      case (funct_q)
         3'd0:          fin_c = prod_c[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fin_c = prod_c[AccW-1:XLEN];
         3'd4, 3'd5:    fin_c = prod_c[XLEN-1:0];
         default:       fin_c = res_neg_q ? XLEN'(-step_c[AccW-1:XLEN]) : step_c[AccW-1:XLEN];
      endcase
   end

`ifdef EX_MULDIV_FAST_MUL_EN
   logic [AccW-1:0] fast_a_c, fast_b_c, fast_prod_c;

   // Single-cycle signed multiply on sign/zero-extended operands
   always_comb begin
      fast_a_c    = {{XLEN{op1_signed_c & s_op1_i[XLEN-1]}}, s_op1_i};
      fast_b_c    = {{XLEN{op2_signed_c & s_op2_i[XLEN-1]}}, s_op2_i};
      fast_prod_c = AccW'(fast_a_c * fast_b_c);
   end
`endif

   // Next-state, datapath and stall decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      funct_d   = funct_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      res_neg_d = res_neg_q;
      result_d  = result_q;
      stall_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_start_i && !s_flush_i) begin
               stall_c   = 1'b1;
               funct_d   = s_funct_i;
               acc_d     = {{XLEN{1'b0}}, (s_funct_i[2] ? op1_mag_c : op2_mag_c)};
               mcand_d   = s_funct_i[2] ? op2_mag_c : op1_mag_c;
               res_neg_d = (s_funct_i[2] && s_funct_i[1]) ? op1_neg_c : (op1_neg_c ^ op2_neg_c);
               cnt_d     = CntW'(XLEN - 1);
               state_d   = CALC;
               if (s_funct_i[2]) begin
                  if (s_op2_i == '0) begin
                     state_d  = DONE;
                     result_d = s_funct_i[1] ? s_op1_i : {XLEN{1'b1}};
                  end else if (!s_funct_i[0] && (s_op1_i == 32'h8000_0000) &&
                               (s_op2_i == 32'hFFFF_FFFF)) begin
                     state_d  = DONE;
                     result_d = s_funct_i[1] ? 32'h0000_0000 : 32'h8000_0000;
                  end
               end
`ifdef EX_MULDIV_FAST_MUL_EN
               else begin
                  state_d  = DONE;
                  result_d = (s_funct_i == 3'd0) ? fast_prod_c[XLEN-1:0] : fast_prod_c[AccW-1:XLEN];
               end
`endif
            end
         end
         CALC: begin
            stall_c = 1'b1;
            acc_d   = step_c;
            if (cnt_q == '0) begin
               state_d  = DONE;
               result_d = fin_c;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         DONE: begin
            if (!s_hold_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (s_flush_i) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // State, datapath and registered status outputs
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         funct_q   <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         res_neg_q <= 1'b0;
         result_q  <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         funct_q   <= funct_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         res_neg_q <= res_neg_d;
         result_q  <= result_d;
         done_q    <= (state_d == DONE);
         busy_q    <= (state_d != IDLE);
      end
   end

   assign s_stall_o  = stall_c;
   assign s_busy_o   = busy_q;
   assign s_done_o   = done_q;
   assign s_result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;

`ifdef EX_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct;
   logic [31:0] op1, op2;
   logic        flush, hold;
   logic        stall, busy, done;
   logic [31:0] result;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ex_muldiv dut (
      .s_clk_i    (clk),
      .s_resetn_i (rst_n),
      .s_start_i  (start),
      .s_funct_i  (funct),
      .s_op1_i    (op1),
      .s_op2_i    (op2),
      .s_flush_i  (flush),
      .s_hold_i   (hold),
      .s_stall_o  (stall),
      .s_busy_o   (busy),
      .s_done_o   (done),
      .s_result_o (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation and check stall, latency and result; ends in DONE (or later)
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
      int lat;
      int stalls;
      @(negedge clk);
      start = 1'b1; funct = f; op1 = a; op2 = b;
      #1 chk({tag, "_stall_T"}, 32'(stall), 32'd1);
      @(negedge clk);
      start = 1'b0;
      lat = 1; stalls = 1;
      while (!done && lat < 100) begin
         if (stall) stalls++;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_stall_in_done"}, 32'(stall), 32'd0);
      if (!hold) begin
         @(negedge clk);
         chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
         chk({tag, "_result_kept"}, result, exp_res);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; funct = 3'd0; op1 = '0; op2 = '0;
      flush = 1'b0; hold = 1'b0;
      #1;
      chk("reset_outputs", {busy, done, stall, result[28:0]}, 32'd0);
      chk("reset_result", result, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("div_neg",   3'd4, 32'hFFFF_FF9C, 32'd7,        33, 32'hFFFF_FFF2);
      run_op("rem_neg",   3'd6, 32'hFFFF_FF9C, 32'd7,        33, 32'hFFFF_FFFE);
      run_op("divu_zero", 3'd5, 32'd5,         32'd0,        1,  32'hFFFF_FFFF);
      run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
      run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
      run_op("rem_zero",  3'd6, 32'hFFFF_FF9C, 32'd0,        1,  32'hFFFF_FF9C);
      run_op("mulh",      3'd1, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000);
      run_op("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE);
      run_op("mul",       3'd0, 32'd3,         32'hFFFF_FFFC, MUL_LAT, 32'hFFFF_FFF4);
      run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFF);
      run_op("divu_big",  3'd5, 32'hFFFF_FFFF, 32'd16,       33, 32'h0FFF_FFFF);
      run_op("remu",      3'd7, 32'd20,        32'd6,        33, 32'd2);

      // Hold in DONE: result and done stable, start ignored
      hold = 1'b1;
      run_op("div_hold", 3'd4, 32'd100, 32'd7, 33, 32'd14);
      for (int i = 0; i < 5; i++) begin
         chk("hold_done", 32'(done), 32'd1);
         chk("hold_result", result, 32'd14);
         if (i == 2) begin
            start = 1'b1; funct = 3'd5; op1 = 32'd9; op2 = 32'd0;
         end else begin
            start = 1'b0;
         end
         if (i == 4) hold = 1'b0;
         @(negedge clk);
      end
      chk("hold_release_idle", {30'd0, busy, done}, 32'd0);
      chk("hold_release_result", result, 32'd14);

      // Flush at T+12 of a DIVU
      @(negedge clk);
      start = 1'b1; funct = 3'd5; op1 = 32'd1000; op2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      chk("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_idle", {29'd0, busy, done, stall}, 32'd0);
      chk("flush_result_kept", result, 32'd14);
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(negedge clk);
         end
         chk("flush_no_done", 32'(seen), 32'd0);
      end

      // Flush and start together: start not accepted
      start = 1'b1; flush = 1'b1; funct = 3'd5; op1 = 32'd7; op2 = 32'd0;
      #1 chk("flush_start_stall", 32'(stall), 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start_idle", {30'd0, busy, done}, 32'd0);
      chk("flush_start_result", result, 32'd14);

      // Reset at T+10 of a DIV
      start = 1'b1; funct = 3'd4; op1 = 32'd500; op2 = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1 chk("rst_mid_outputs", {29'd0, busy, done, stall}, 32'd0);
      chk("rst_mid_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst_divu", 3'd5, 32'd20, 32'd6, 33, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
